// File: rtl/updown_counter_gen_if.sv
// Control and status bundle for updown_counter_gen.
// The master side drives the controls; the slave side is the counter itself.
interface updown_counter_gen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_down;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flags;
  logic [WIDTH-1:0] counter;
  logic             at_max;
  logic             at_min;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport master (
    output en, up_down, sat_mode, load, load_val, clr_flags,
    input  counter, at_max, at_min, tc, ovf, unf
  );

  modport slave (
    input  en, up_down, sat_mode, load, load_val, clr_flags,
    output counter, at_max, at_min, tc, ovf, unf
  );
endinterface

// File: rtl/updown_counter_gen.sv
// Up/down counter over 0..MAX_VAL with parallel load, wrap or saturate at the
// bounds, a terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_gen #(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input logic                clk,
  input logic                reset,
  updown_counter_gen_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_gen: WIDTH must be in 2..32");
  end
  if (MAX_VAL == 64'd0 || MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("updown_counter_gen: MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_reset
    $error("updown_counter_gen: RESET_VAL must not exceed MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, unf_q;
  logic             ovf_set, unf_set;
  logic             at_max_w, at_min_w;

  assign at_max_w = (count_q == MAX_W);
  assign at_min_w = (count_q == '0);

  // Boundary compares use MAX_VAL so that non-power-of-two moduli wrap correctly.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (at_max_w) begin
          tc_d    = 1'b1;
          ovf_set = 1'b1;
          count_d = bus.sat_mode ? MAX_W : '0;
        end else begin
          count_d = count_q + ONE_W;
        end
      end else begin
        if (at_min_w) begin
          tc_d    = 1'b1;
          unf_set = 1'b1;
          count_d = bus.sat_mode ? '0 : MAX_W;
        end else begin
          count_d = count_q - ONE_W;
        end
      end
    end
  end

  // A new boundary event wins over a coincident clr_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_W;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_set | (ovf_q & ~bus.clr_flags);
      unf_q   <= unf_set | (unf_q & ~bus.clr_flags);
    end
  end

  assign bus.counter = count_q;
  assign bus.at_max  = at_max_w;
  assign bus.at_min  = at_min_w;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench: a full-range (MAX_VAL=15) and a short-modulus (MAX_VAL=9)
// counter share one stimulus stream; expectations are queued per edge.
module tb_updown_counter_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_down, sat_mode, load, clr_flags;
  logic [3:0] load_val;

  updown_counter_gen_if #(.WIDTH(4)) if15 ();
  updown_counter_gen_if #(.WIDTH(4)) if9 ();

  assign if15.en = en;        assign if9.en = en;
  assign if15.up_down = up_down;   assign if9.up_down = up_down;
  assign if15.sat_mode = sat_mode; assign if9.sat_mode = sat_mode;
  assign if15.load = load;    assign if9.load = load;
  assign if15.load_val = load_val; assign if9.load_val = load_val;
  assign if15.clr_flags = clr_flags; assign if9.clr_flags = clr_flags;

  updown_counter_gen #(.WIDTH(4)) dut15 (.clk(clk), .reset(reset), .bus(if15.slave));
  updown_counter_gen #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) dut9 (
    .clk(clk), .reset(reset), .bus(if9.slave));

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    bit tc;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   maxv[2] = '{15, 9};
  int   m_cnt[2];
  bit   m_tc[2], m_ovf[2], m_unf[2];

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input int i, input bit r, input bit e, input bit ud,
                                input bit s, input bit l, input int lv, input bit c);
    bit set_o, set_u;
    set_o = 1'b0;
    set_u = 1'b0;
    if (r) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      return;
    end
    m_tc[i] = 0;
    if (l) begin
      m_cnt[i] = (lv > maxv[i]) ? maxv[i] : lv;
    end else if (e) begin
      if (ud) begin
        if (m_cnt[i] == maxv[i]) begin
          m_tc[i] = 1; set_o = 1;
          m_cnt[i] = s ? maxv[i] : 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end else begin
        if (m_cnt[i] == 0) begin
          m_tc[i] = 1; set_u = 1;
          m_cnt[i] = s ? 0 : maxv[i];
        end else m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_ovf[i] = set_o | (m_ovf[i] & ~c);
    m_unf[i] = set_u | (m_unf[i] & ~c);
  endfunction

  task automatic step(input bit r, input bit e, input bit ud, input bit s,
                      input bit l, input int lv, input bit c);
    exp_t x;
    reset = r; en = e; up_down = ud; sat_mode = s; load = l; clr_flags = c;
    load_val = 4'(lv);
    for (int i = 0; i < 2; i++) begin
      model(i, r, e, ud, s, l, lv, c);
      x.idx = i; x.cnt = m_cnt[i]; x.tc = m_tc[i]; x.ovf = m_ovf[i]; x.unf = m_unf[i];
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      int         cnt;
      logic       amax, amin, tcv, ov, un;
      string      p;
      x = sb.pop_front();
      if (x.idx == 0) begin
        cnt = int'(if15.counter); amax = if15.at_max; amin = if15.at_min;
        tcv = if15.tc; ov = if15.ovf; un = if15.unf;
      end else begin
        cnt = int'(if9.counter); amax = if9.at_max; amin = if9.at_min;
        tcv = if9.tc; ov = if9.ovf; un = if9.unf;
      end
      p = $sformatf("max%0d", maxv[x.idx]);
      chk({p, " counter"}, cnt, x.cnt);
      chk({p, " tc"}, int'(tcv), int'(x.tc));
      chk({p, " ovf"}, int'(ov), int'(x.ovf));
      chk({p, " unf"}, int'(un), int'(x.unf));
      chk({p, " at_max"}, int'(amax), int'(x.cnt == maxv[x.idx]));
      chk({p, " at_min"}, int'(amin), int'(x.cnt == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_val = '0; clr_flags = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
    #2;

    // reset with en low
    step(1, 0, 1, 0, 0, 0, 0);

    // up wrap for 12 cycles
    for (int k = 0; k < 12; k++) step(0, 1, 1, 0, 0, 0, 0);

    // load 2, then down saturate for 4 cycles
    step(0, 0, 0, 1, 1, 2, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 0, 0, 0);

    // load clamp with en high, then reset beats load
    step(0, 1, 1, 0, 1, 13, 0);
    step(1, 1, 1, 0, 1, 13, 0);

    // flag clear, then clear racing a new overflow
    step(0, 0, 1, 0, 1, 9, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 9, 0);
    step(0, 1, 1, 0, 0, 0, 1);

    // count up to 5, reset mid-count, then hold
    step(0, 0, 1, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0, 0);

    // saturate at the top with consecutive boundary steps
    step(0, 0, 1, 1, 1, 15, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0, 0, 0);

    // random mix
    for (int k = 0; k < 150; k++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
- Parametrised up/down counter. It generalises the team's 4-bit up/down counter with configurable width, programmable modulus, parallel load, count enable, and a runtime wrap/saturate mode.
- It adds terminal-count pulses and sticky overflow/underflow flags.
- It is used as a reusable timing/event counter in the control blocks and is verified standalone in its own testbench.

Parameters:
- WIDTH, 4, counter width in bits (legal 2..32).
- MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL. Elaboration error if MAX_VAL is 0 or ≥ 2**WIDTH.
- RESET_VAL, 0, value loaded on reset. Must be ≤ MAX_VAL.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; the counter steps only when en=1.
- up_down  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary mode: 1 = saturate at bound, 0 = wrap modulo MAX_VAL+1.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value for load.
- clr_flags  input  1  clears the sticky ovf/unf flags.
- counter  output  WIDTH  current count, registered.
- at_max  output  1  combinational: counter == MAX_VAL.
- at_min  output  1  combinational: counter == 0.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky: an up step was attempted at MAX_VAL.
- unf  output  1  sticky: a down step was attempted at 0.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Priority per edge: reset > load > en-count > hold.
- Reset:
  - counter = RESET_VAL.
  - tc = 0, ovf = 0, unf = 0.
  - Reset overrides load, en and clr_flags in the same cycle.
- Load (load=1, reset=0):
  - counter = load_val; if load_val > MAX_VAL, counter = MAX_VAL (clamp).
  - No step occurs that cycle; tc = 0; ovf/unf are not set by the load.
- Count (en=1, load=0, reset=0):
  - Up, counter < MAX_VAL: counter+1.
  - Up, counter == MAX_VAL: wrap mode → 0; saturate mode → stays MAX_VAL. In both modes, tc = 1 next cycle and ovf sets.
  - Down, counter > 0: counter−1.
  - Down, counter == 0: wrap mode → MAX_VAL; saturate mode → stays 0. In both modes, tc = 1 next cycle and unf sets.
- Hold (en=0, no load): counter unchanged, tc = 0.
- tc:
  - One-cycle pulse, high exactly in the cycle after a boundary step. Low otherwise.
  - Consecutive boundary steps in saturate mode keep tc high for each such cycle.
- Arithmetic:
  - Compare against MAX_VAL, not against 2**WIDTH−1; modulus is MAX_VAL+1.
  - No intermediate value outside WIDTH bits reaches the register.
- Sticky flags:
  - ovf/unf hold until clr_flags=1 or reset.
  - If clr_flags and a new boundary event coincide, the flag is set (set wins).
  - clr_flags clears both flags.
- Mode and direction:
  - sat_mode and up_down may change on any cycle and take effect on the same edge.
  - No internal state depends on their previous values.
- Latency: counter, tc, ovf and unf reflect the inputs of edge N after edge N. at_max/at_min follow counter combinationally.
- Reset mid-operation: any cycle, same result as the reset defaults; a pending tc is dropped.

Test Plan:
- Reset, default parameters (WIDTH=4, MAX_VAL=15):
  - Stimulus: reset=1 for 1 cycle, en=0.
  - Required: counter=0, at_min=1, tc=0, ovf=0, unf=0.
- Up wrap, MAX_VAL=9:
  - Stimulus: en=1, up_down=1, sat_mode=0 for 12 cycles from 0.
  - Required: counter 1..9, 0, 1, 2.
  - Required: tc=1 only in the cycle after 9→0; ovf=1 from then on.
- Down saturate, MAX_VAL=9:
  - Stimulus: load 2, then en=1, up_down=0, sat_mode=1 for 4 cycles.
  - Required: counter 1, 0, 0, 0.
  - Required: tc=1 in the last two cycles; unf=1 and stays; counter never reads 9.
- Load clamp and priority, MAX_VAL=9:
  - Stimulus: load_val=13 with load=1 and en=1.
  - Required: counter=9, at_max=1, ovf unchanged.
  - Stimulus: same cycle with reset=1 and load=1.
  - Required: counter=0.
- Flag clear race:
  - Stimulus: ovf=1; pulse clr_flags with en=0.
  - Required: ovf=0.
  - Stimulus: clr_flags=1 with an up step at MAX_VAL.
  - Required: ovf=1.
- Mid-count reset and hold:
  - Stimulus: counting up at 5, assert reset for 1 cycle.
  - Required: counter=0, tc=0.
  - Stimulus: en=0 for 5 cycles.
  - Required: counter holds 0, tc=0.
